// File: rtl/arb_pkg.sv
// Shared types and helpers for the packet arbiters.
// Holds the FSM state encoding and a one-hot to index converter.
package arb_pkg;

   typedef enum logic {
      ARB_IDLE,
      ARB_LOCKED
   } arb_state_t;

   // Covers up to 16 requesters; callers zero-extend and truncate around it.
   function automatic logic [3:0] onehot2idx(input logic [15:0] oh);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (oh[i]) idx = idx | 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: lowest request at or above the slot after last_grant, wrapping.
// Reusable by any arbiter that keeps its own one-hot last_grant register.
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] last_grant,
   output logic [N-1:0] grant
);

   logic [N-1:0]   start;
   logic [2*N-1:0] req2;
   logic [2*N-1:0] masked;

   assign start = {last_grant[N-2:0], last_grant[N-1]};
   assign req2  = {req, req};

   // The subtraction borrows through the bits below the first request at or above start;
   // the upper copy supplies the wrap-around candidate.
   assign masked = req2 & ~(req2 - {{N{1'b0}}, start});
   assign grant  = masked[N-1:0] | masked[2*N-1:N];

endmodule

// File: rtl/rr_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one valid/ready stream among N requesters.
// The grant locks to a requester from its first accepted beat until its last beat is accepted.
module rr_packet_arbiter
   import arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = 32,
   localparam int SRC_W = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N-1:0]      in_valid,
   input  logic [N-1:0]      in_last,
   input  logic [N*DW-1:0]   in_data,
   output logic [N-1:0]      in_ready,
   output logic              out_valid,
   output logic              out_last,
   output logic [DW-1:0]     out_data,
   input  logic              out_ready,
   output logic [SRC_W-1:0]  out_src,
   output logic              pkt_done,
   output logic              busy
);

   arb_state_t       state;
   logic [N-1:0]     last_grant;
   logic [SRC_W-1:0] owner;

   logic [N-1:0]     pick_oh;
   logic [SRC_W-1:0] pick_idx;
   logic [N-1:0]     owner_oh;
   logic [N-1:0]     sel_oh;
   logic [SRC_W-1:0] sel_idx;
   logic             sel_valid;
   logic             hs;
   logic [DW-1:0]    lane [N];

   for (genvar g = 0; g < N; g++) begin : g_lane
      assign lane[g] = in_data[g*DW +: DW];
   end

   rr_pick #(.N(N)) u_pick (
      .req        (in_valid),
      .last_grant (last_grant),
      .grant      (pick_oh)
   );

   assign pick_idx = SRC_W'(onehot2idx(16'(pick_oh)));
   assign owner_oh = {{(N-1){1'b0}}, 1'b1} << owner;

   assign sel_idx   = (state == ARB_LOCKED) ? owner    : pick_idx;
   assign sel_oh    = (state == ARB_LOCKED) ? owner_oh : pick_oh;
   assign sel_valid = (state == ARB_LOCKED) ? in_valid[owner] : |in_valid;

   // Outputs are a zero-latency mux; they are forced quiet while reset is held.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_data  = '0;
      out_src   = '0;
      in_ready  = '0;
      if (rst_n) begin
         out_valid = sel_valid;
         out_last  = in_last[sel_idx];
         out_data  = lane[sel_idx];
         out_src   = sel_idx;
         if (sel_valid) in_ready = sel_oh & {N{out_ready}};
      end
   end

   assign hs = out_valid & out_ready;

   // Priority pointer moves only when a packet completes; stalls and mid-packet beats leave it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB_IDLE;
         last_grant <= {1'b1, {(N-1){1'b0}}};
         owner      <= '0;
         pkt_done   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         pkt_done <= hs & out_last;
         case (state)
            ARB_IDLE: begin
               if (hs) begin
                  if (out_last) begin
                     last_grant <= pick_oh;
                  end else begin
                     state <= ARB_LOCKED;
                     owner <= pick_idx;
                     busy  <= 1'b1;
                  end
               end
            end
            ARB_LOCKED: begin
               if (hs && out_last) begin
                  state      <= ARB_IDLE;
                  last_grant <= owner_oh;
                  busy       <= 1'b0;
               end
            end
            default: begin
               state <= ARB_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/rr_packet_arbiter.md
Name: rr_packet_arbiter

Overview:
Shares one downstream valid/ready stream port between N upstream requesters at packet granularity. Arbitration is round-robin. The grant is locked to the winning requester from its first accepted beat until its last beat is accepted, so packets are never interleaved. It sits in front of any shared single-port resource (bus master port, FIFO write side, DMA channel) and reuses the double-width request-minus-pointer round-robin pick.

Parameters:
N, 4, number of requesters (2..16)
DW, 32, data width per beat
SRC_W, $clog2(N), width of source index (derived, localparam)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  N  per-requester beat valid
in_last  in  N  per-requester last-beat-of-packet flag
in_data  in  N*DW  per-requester beat data, requester i at [i*DW +: DW]
in_ready  out  N  per-requester ready, at most one bit set
out_valid  out  1  downstream beat valid
out_last  out  1  downstream last flag
out_data  out  DW  downstream beat data
out_ready  in  1  downstream ready
out_src  out  SRC_W  index of requester driving the current beat
pkt_done  out  1  one-cycle pulse, registered, after each accepted last beat
busy  out  1  1 while in LOCKED state

Behaviour:
- State machine, two states: IDLE, LOCKED. Reset state is IDLE.
- last_grant register: one-hot, N bits. Reset value is one-hot bit N-1, so requester 0 has top priority after reset.
- Pick is combinational: the start mask is last_grant rotated left by 1. pick = lowest set bit of in_valid at or above start, with wrap-around. Use the double-width form {v,v} & ~({v,v} - start), folded back to N bits.
- IDLE:
  - If in_valid==0: out_valid=0, in_ready=0.
  - Else winner = pick. out_valid=1, and out_data/out_last/out_src come from the winner in the same cycle (zero latency). in_ready[winner]=out_ready.
  - Handshake (out_valid&&out_ready) with out_last=1 (single-beat packet): stay IDLE, last_grant<=winner, pkt_done<=1 next cycle.
  - Handshake with out_last=0: go to LOCKED, owner<=winner.
  - No handshake: no state change. The pick is re-evaluated each cycle; a grant offered in IDLE is not sticky before acceptance.
- LOCKED:
  - Only the owner is muxed. out_valid=in_valid[owner], in_ready[owner]=out_ready, all other in_ready=0.
  - A handshake with out_last=1 returns to IDLE, sets last_grant<=one-hot(owner), and pulses pkt_done next cycle.
  - Owner bubbles (in_valid[owner]=0) hold LOCKED indefinitely; there is no timeout.
- Pointer updates only on packet completion, never on a stalled offer or a mid-packet beat.
- The same requester wins back-to-back only if no other requester is valid.
- in_ready is one-hot or zero in every cycle; out_src equals the owner in LOCKED.
- Reset outputs: out_valid=0, in_ready=0, out_last=0, out_data=0, out_src=0, pkt_done=0, busy=0.
- Reset mid-packet: the FSM returns to IDLE and priority returns to requester 0. The partial packet is the upstream's problem and there is no recovery handshake.
- Upstream must hold in_valid/in_data stable until ready (AXI-stream rule). The block does not check this.

Decomposition:
- Package arb_pkg: typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t; function onehot2idx(); localparam-free helpers only.
- Sub-module rr_pick: combinational. Inputs are req[N] and last_grant[N]; output is grant[N] one-hot. It is reusable by other arbiters.
- Top level holds the FSM, last_grant, owner, the output mux, and the pkt_done flop.

Test Plan:
- Reset, then in_valid=4'b1111, all single-beat packets, out_ready=1 -> out_src sequence 0,1,2,3,0; pkt_done pulses every cycle from cycle 2.
- Req1 sends a 3-beat packet while req2 is valid throughout -> out_src=1 for 3 accepted beats, then 2; in_ready[2]=0 during req1's packet.
- Req0 is mid-packet, deasserts valid for 2 cycles, and req3 is valid -> out_valid=0 for 2 cycles, busy=1, req3 not granted until req0's last beat.
- out_ready=0 for 4 cycles with in_valid=4'b0110 and last_grant=bit0 -> out_src=1 held, last_grant unchanged; after release req1 is accepted, then req2.
- rst_n asserted asynchronously during beat 2 of a 4-beat req2 packet -> outputs are zero immediately; after release with in_valid=4'b0101, out_src=0.
- Only req3 is valid, with repeated single-beat packets -> req3 is granted every cycle (no idle gap); in_ready==4'b1000.
